// File: rtl/fp_pkg.sv
// Shared widths and field positions for the floating-point adder datapath.
// Extended significand layout: {hidden, fraction, G, R, S}, sticky at bit 0.
package fp_pkg;

   localparam int SIG_BITS = 23;
   localparam int EXP_BITS = 8;
   localparam int W        = SIG_BITS + 4;

   localparam int GUARD  = 2;
   localparam int ROUND  = 1;
   localparam int STICKY = 0;

   typedef logic [W-1:0] sig_ext_t;

   // Shift bits that actually steer the barrel; any bit above these saturates.
   function automatic int stage_count(input int exp_bits, input int w);
      int shw;
      shw = $clog2(w);
      return (exp_bits < shw) ? exp_bits : shw;
   endfunction

endpackage

// File: rtl/sticky_mask.sv
// Purpose: OR of every significand bit a right shift would discard, saturating at shift >= W.
// Latency: combinational. Backpressure: none.
module sticky_mask
   import fp_pkg::*;
#(
   parameter int SIG_BITS = fp_pkg::SIG_BITS,
   parameter int EXP_BITS = fp_pkg::EXP_BITS
) (
   input  logic [SIG_BITS+3:0] i_sig2,
   input  logic [EXP_BITS-1:0] i_shift,
   output logic                o_lost
);

   localparam int W   = SIG_BITS + 4;
   localparam int NST = stage_count(EXP_BITS, W);

   logic         w_sat;
   logic [W-1:0] w_mask;

   if (EXP_BITS >= $clog2(W)) begin : g_sat
      localparam logic [EXP_BITS:0] W_LIM = (EXP_BITS+1)'(W);
      assign w_sat = ({1'b0, i_shift} >= W_LIM);
   end else begin : g_nosat
      assign w_sat = 1'b0;
   end

   // Mask covers bit positions [shift-1:0], the ones falling off the LSB end.
   assign w_mask = w_sat ? {W{1'b1}} : ~({W{1'b1}} << i_shift[NST-1:0]);
   assign o_lost = |(i_sig2 & w_mask);

endmodule

// File: rtl/align_significands.sv
// Purpose: right-align the smaller operand's extended significand by the exponent difference (ALIGN_STICKY_EN folds lost bits into sticky).
// Latency: 1 cycle, one result per in_valid, back-to-back supported.
// Backpressure: none; output holds between valids.
module align_significands
   import fp_pkg::*;
#(
   parameter int SIG_BITS = fp_pkg::SIG_BITS,
   parameter int EXP_BITS = fp_pkg::EXP_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [SIG_BITS+3:0] sig2,
   input  logic [EXP_BITS-1:0] shift,
   output logic                out_valid,
   output logic [SIG_BITS+3:0] sig2_aligned
);

   localparam int W   = SIG_BITS + 4;
   localparam int NST = stage_count(EXP_BITS, W);

   logic         w_sat;
   logic [W-1:0] w_stage [0:NST];
   logic [W-1:0] w_shifted;
   logic [W-1:0] w_result;
   logic         r_out_valid;
   logic [W-1:0] r_sig2_aligned;

   // Shift amounts at or beyond W must not wrap through the truncated barrel controls.
   if (EXP_BITS >= $clog2(W)) begin : g_sat
      localparam logic [EXP_BITS:0] W_LIM = (EXP_BITS+1)'(W);
      assign w_sat = ({1'b0, shift} >= W_LIM);
   end else begin : g_nosat
      assign w_sat = 1'b0;
   end

   assign w_stage[0] = sig2;

   for (genvar i = 0; i < NST; i++) begin : g_barrel
      assign w_stage[i+1] = shift[i] ? (w_stage[i] >> (1 << i)) : w_stage[i];
   end

   assign w_shifted = w_sat ? '0 : w_stage[NST];

`ifdef ALIGN_STICKY_EN
   logic w_lost;

   sticky_mask #(
      .SIG_BITS (SIG_BITS),
      .EXP_BITS (EXP_BITS)
   ) u_sticky_mask (
      .i_sig2  (sig2),
      .i_shift (shift),
      .o_lost  (w_lost)
   );

   assign w_result = {w_shifted[W-1:STICKY+1], w_shifted[STICKY] | w_lost};
`else
   assign w_result = w_shifted;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid    <= 1'b0;
         r_sig2_aligned <= '0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_sig2_aligned <= w_result;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign sig2_aligned = r_sig2_aligned;

endmodule

// File: tb/tb_align_significands.sv
// Directed and swept checks for align_significands; expectations follow the ALIGN_STICKY_EN setting.
module tb_align_significands;
   import fp_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   sig_ext_t   sig2;
   logic [7:0] shift;
   logic       out_valid;
   sig_ext_t   sig2_aligned;

   int n_checks;
   int n_fail;

   align_significands dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .sig2         (sig2),
      .shift        (shift),
      .out_valid    (out_valid),
      .sig2_aligned (sig2_aligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-by-bit reference: destination bit i takes source bit i+sh.
   function automatic sig_ext_t ref_align(input sig_ext_t s, input int sh);
      sig_ext_t r;
      logic     lost;
      r    = '0;
      lost = 1'b0;
      for (int i = 1; i < W; i++) begin
         if (i + sh < W) r[i] = s[i+sh];
      end
      if (sh < W) r[0] = s[sh];
`ifdef ALIGN_STICKY_EN
      for (int j = 0; j < W; j++) begin
         if (j < sh) lost = lost | s[j];
      end
      r[0] = r[0] | lost;
`endif
      return r;
   endfunction

   task automatic apply_one(input sig_ext_t s, input logic [7:0] sh);
      @(negedge clk);
      in_valid = 1'b1;
      sig2     = s;
      shift    = sh;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic check_vec(input string name, input sig_ext_t s, input logic [7:0] sh,
                            input sig_ext_t exp_v);
      apply_one(s, sh);
      n_checks++;
      if (sig2_aligned !== exp_v || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got sig2_aligned=%h out_valid=%b, expected %h valid=1",
                  name, sig2_aligned, out_valid, exp_v);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      sig2     = '0;
      shift    = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sig2_aligned !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%b data=%h, expected 0/0", out_valid, sig2_aligned);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      sig_ext_t e_sticky;
      sig_ext_t e_sat;
      sig_ext_t e_wrap;
      sig_ext_t e_sat_one;
`ifdef ALIGN_STICKY_EN
      e_sticky  = 27'h0400001;
      e_sat     = 27'h0000001;
      e_wrap    = 27'h0000001;
      e_sat_one = 27'h0000001;
`else
      e_sticky  = 27'h0400000;
      e_sat     = 27'h0000000;
      e_wrap    = 27'h0000000;
      e_sat_one = 27'h0000000;
`endif
      check_vec("shift0",      27'h4000000, 8'd0,   27'h4000000);
      check_vec("shift3",      27'h4000000, 8'd3,   27'h0800000);
      check_vec("sticky4",     27'h4000008, 8'd4,   e_sticky);
      check_vec("sat27",       27'h7FFFFC0, 8'd27,  e_sat);
      check_vec("sat255_zero", 27'h0000000, 8'd255, 27'h0000000);
      check_vec("shift26",     27'h4000000, 8'd26,  27'h0000001);
      check_vec("nowrap32",    27'h4000000, 8'd32,  e_wrap);
      check_vec("sat255_lsb",  27'h0000001, 8'd255, e_sat_one);
      check_vec("shift0_lsb",  27'h0000005, 8'd0,   27'h0000005);
   endtask

   task automatic test_hold();
      apply_one(27'h5A5A5A5, 8'd1);
      @(negedge clk);
      sig2  = 27'h1234567;
      shift = 8'd2;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sig2_aligned !== ref_align(27'h5A5A5A5, 1)) begin
         n_fail++;
         $display("FAIL hold: got valid=%b data=%h, expected 0/%h",
                  out_valid, sig2_aligned, ref_align(27'h5A5A5A5, 1));
      end
   endtask

   task automatic test_back_to_back();
      sig_ext_t s_q[$];
      int       hi_cnt;
      sig_ext_t s;
      hi_cnt = 0;
      for (int k = 0; k <= 15; k++) begin
         @(negedge clk);
         if (k > 0) begin
            n_checks++;
            if (sig2_aligned !== ref_align(s_q[k-1], k - 1)) begin
               n_fail++;
               $display("FAIL sweep_shift%0d: got %h, expected %h",
                        k - 1, sig2_aligned, ref_align(s_q[k-1], k - 1));
            end
            if (out_valid === 1'b1) hi_cnt++;
         end
         if (k < 15) begin
            s        = sig_ext_t'($urandom) & ~sig_ext_t'(6'h3F);
            s_q.push_back(s);
            in_valid = 1'b1;
            sig2     = s;
            shift    = 8'(k);
         end else begin
            in_valid = 1'b0;
         end
      end
      n_checks++;
      if (hi_cnt != 15) begin
         n_fail++;
         $display("FAIL sweep_valid_run: got %0d high cycles, expected 15", hi_cnt);
      end
   endtask

   task automatic test_reset_midop();
      apply_one(27'h4000000, 8'd1);
      @(negedge clk);
      in_valid = 1'b1;
      sig2     = 27'h7FFFFFF;
      shift    = 8'd0;
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || sig2_aligned !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got valid=%b data=%h, expected 0/0", out_valid, sig2_aligned);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sig2_aligned !== '0) begin
         n_fail++;
         $display("FAIL reset_no_stale: got valid=%b data=%h, expected 0/0", out_valid, sig2_aligned);
      end
      check_vec("after_reset", 27'h4000000, 8'd2, 27'h1000000);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_directed();
      test_hold();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
